// File: rtl/idex_pipe_stage_if.sv
// idex_pipe_stage_if
// Bundle of the decode-side and execute-side signals around the ID/EX
// pipeline register. Signal names match the original flat port list.
//   master : surrounding pipeline (drives decode payload, flush, ex_ready)
//   slave  : idex_pipe_stage (drives id_ready, registered ex_* payload, hazard)
// Parameters: XLEN (datapath width), REG_ADDR_W (register specifier width),
//             CTRL_W (packed control bundle width).
interface idex_pipe_stage_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CTRL_W     = 16
) ();
  logic                  flush;
  logic                  id_valid;
  logic                  id_ready;
  logic [XLEN-1:0]       id_pc;
  logic [31:0]           id_inst;
  logic [XLEN-1:0]       id_rs1_val;
  logic [XLEN-1:0]       id_rs2_val;
  logic [XLEN-1:0]       id_imm;
  logic [CTRL_W-1:0]     id_ctrl;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic                  id_is_load;
  logic                  ex_valid;
  logic                  ex_ready;
  logic [XLEN-1:0]       ex_pc;
  logic [XLEN-1:0]       ex_rs1_val;
  logic [XLEN-1:0]       ex_rs2_val;
  logic [XLEN-1:0]       ex_imm;
  logic [CTRL_W-1:0]     ex_ctrl;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_is_load;
  logic                  hazard;

  modport master (
    output flush, id_valid, id_pc, id_inst, id_rs1_val, id_rs2_val, id_imm,
           id_ctrl, id_uses_rs1, id_uses_rs2, id_is_load, ex_ready,
    input  id_ready, ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm,
           ex_ctrl, ex_rd, ex_is_load, hazard
  );

  modport slave (
    input  flush, id_valid, id_pc, id_inst, id_rs1_val, id_rs2_val, id_imm,
           id_ctrl, id_uses_rs1, id_uses_rs2, id_is_load, ex_ready,
    output id_ready, ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm,
           ex_ctrl, ex_rd, ex_is_load, hazard
  );
endinterface

// File: rtl/idex_pipe_stage.sv
// idex_pipe_stage
// Decode/execute pipeline register with valid/ready handshake. Holds its
// payload under back-pressure, inserts one bubble on a load-use hazard and
// empties on a branch/jump flush.
// Ports:
//   CLK        : clock, rising edge
//   RSTN       : asynchronous active-low reset
//   bus        : idex_pipe_stage_if.slave (decode payload in, ex payload out,
//                flush, id_ready/ex_ready handshake, hazard)
//   stall_cnt  : (IDEX_PERF_CNT_EN only) edges with ex_valid & ~ex_ready
//   bubble_cnt : (IDEX_PERF_CNT_EN only) edges where a hazard empties the stage
// Optional feature macro: IDEX_PERF_CNT_EN
module idex_pipe_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CTRL_W     = 16
) (
  input  logic            CLK,
  input  logic            RSTN,
  idex_pipe_stage_if.slave bus
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     bubble_cnt
`endif
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } occ_t;

  occ_t                  state, state_nxt;
  logic                  ex_valid;
  logic                  hazard;
  logic                  id_ready;
  logic                  accept;
  logic                  load_en;
  logic [REG_ADDR_W-1:0] rs1, rs2, rd_in;

  logic [XLEN-1:0]       pc_q, rs1_val_q, rs2_val_q, imm_q;
  logic [CTRL_W-1:0]     ctrl_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  is_load_q;

  assign rs1   = REG_ADDR_W'(bus.id_inst[19:15]);
  assign rs2   = REG_ADDR_W'(bus.id_inst[24:20]);
  assign rd_in = REG_ADDR_W'(bus.id_inst[11:7]);

  assign ex_valid = (state == S_FULL);

  // Only the registered (held) instruction can be a producing load; x0 is
  // never a real dependency, and unused source fields are ignored.
  assign hazard = bus.id_valid & ex_valid & is_load_q & (rd_q != '0) &
                  ((bus.id_uses_rs1 & (rd_q == rs1)) |
                   (bus.id_uses_rs2 & (rd_q == rs2)));

  assign id_ready = ~bus.flush & ~hazard & (~ex_valid | bus.ex_ready);
  assign accept   = bus.id_valid & id_ready;

  // Flush wins over everything; an accept may replace a departing
  // instruction in the same edge; otherwise a consumed instruction leaves
  // a bubble (this is also how the hazard bubble is formed).
  always_comb begin
    state_nxt = state;
    load_en   = 1'b0;
    if (bus.flush) begin
      state_nxt = S_EMPTY;
    end else if (accept) begin
      state_nxt = S_FULL;
      load_en   = 1'b1;
    end else if (ex_valid && bus.ex_ready) begin
      state_nxt = S_EMPTY;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= S_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      pc_q      <= '0;
      rs1_val_q <= '0;
      rs2_val_q <= '0;
      imm_q     <= '0;
      ctrl_q    <= '0;
      rd_q      <= '0;
      is_load_q <= 1'b0;
    end else if (load_en) begin
      pc_q      <= bus.id_pc;
      rs1_val_q <= bus.id_rs1_val;
      rs2_val_q <= bus.id_rs2_val;
      imm_q     <= bus.id_imm;
      ctrl_q    <= bus.id_ctrl;
      rd_q      <= rd_in;
      is_load_q <= bus.id_is_load;
    end
  end

  assign bus.id_ready   = id_ready;
  assign bus.hazard     = hazard;
  assign bus.ex_valid   = ex_valid;
  assign bus.ex_pc      = pc_q;
  assign bus.ex_rs1_val = rs1_val_q;
  assign bus.ex_rs2_val = rs2_val_q;
  assign bus.ex_imm     = imm_q;
  assign bus.ex_ctrl    = ctrl_q;
  assign bus.ex_rd      = rd_q;
  assign bus.ex_is_load = is_load_q;

`ifdef IDEX_PERF_CNT_EN
  // A hazard always sits on a held load; when execute takes that load the
  // stage empties because of the hazard, which is what bubble_cnt records.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (ex_valid && !bus.ex_ready) stall_cnt  <= stall_cnt + 32'd1;
      if (hazard && bus.ex_ready)    bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule
